// File: rtl/cv32e40s_clmul_seq.sv
// Sequential carry-less multiplier (clmul/clmulh/clmulr) retiring STEP rs2 bits per BUSY cycle; result held in DONE until ready_i.
// Latency N+1 from accept (N=32/STEP); with CV32E40S_CLMUL_EARLY_TERM_EN defined, BUSY ends once the remaining rs2 bits are zero.
module cv32e40s_clmul_seq #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o
);

    localparam int N     = 32 / STEP;
    localparam int CNT_W = $clog2(N) + 1;

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16 || STEP == 32)) begin : g_bad_step
            $error("cv32e40s_clmul_seq: STEP must be one of 1, 2, 4, 8, 16, 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [63:0]        acc_q;
    logic [63:0]        a_sh_q;
    logic [31:0]        b_sh_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [63:0]        partial;
    logic [63:0]        acc_nxt;
    logic [63:0]        a_sh_nxt;
    logic [31:0]        b_sh_nxt;
    logic [31:0]        res_sel;
    logic               last;
    logic               accept;
    logic               step;
    logic               zero_b;

    always_comb begin
        partial = '0;
        for (int j = 0; j < STEP; j++) begin
            if (b_sh_q[j]) begin
                partial = partial ^ (a_sh_q << j);
            end
        end
        acc_nxt  = acc_q ^ partial;
        a_sh_nxt = a_sh_q << STEP;
        b_sh_nxt = 32'({32'b0, b_sh_q} >> STEP);
`ifdef CV32E40S_CLMUL_EARLY_TERM_EN
        last     = (cnt_q == CNT_W'(N - 1)) || (b_sh_nxt == 32'b0);
        zero_b   = (op_b_i == 32'b0);
`else
        last     = (cnt_q == CNT_W'(N - 1));
        zero_b   = 1'b0;
`endif
        case (op_q)
            2'b01:   res_sel = acc_nxt[63:32];
            2'b10:   res_sel = acc_nxt[62:31];
            default: res_sel = acc_nxt[31:0];
        endcase
    end

    // Kill overrides every other transition, including accept and completion.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    accept  = 1'b1;
                    state_d = zero_b ? DONE : BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (kill_i) begin
            state_d = IDLE;
            accept  = 1'b0;
            step    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_o <= '0;
        end else if (accept) begin
            acc_q  <= '0;
            a_sh_q <= {32'b0, op_a_i};
            b_sh_q <= op_b_i;
            op_q   <= op_i;
            cnt_q  <= '0;
            if (zero_b) begin
                result_o <= '0;
            end
        end else if (step) begin
            acc_q  <= acc_nxt;
            a_sh_q <= a_sh_nxt;
            b_sh_q <= b_sh_nxt;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last) begin
                result_o <= res_sel;
            end
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);

endmodule

// File: tb/tb_cv32e40s_clmul_seq.sv
module tb_cv32e40s_clmul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    logic        sw_valid;
    logic        sw_ready;
    logic [1:0]  sw_op;
    logic [31:0] sw_a;
    logic [31:0] sw_b;
    logic [5:0]  sw_valid_o;
    logic [5:0]  sw_ready_o;
    logic [31:0] sw_res [6];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cv32e40s_clmul_seq #(.STEP(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
    );

    genvar g;
    generate
        for (g = 0; g < 6; g++) begin : g_sw
            cv32e40s_clmul_seq #(.STEP(1 << g)) u_sw (
                .clk      (clk),
                .rst      (rst),
                .valid_i  (sw_valid),
                .ready_o  (sw_ready_o[g]),
                .op_i     (sw_op),
                .op_a_i   (sw_a),
                .op_b_i   (sw_b),
                .kill_i   (1'b0),
                .valid_o  (sw_valid_o[g]),
                .ready_i  (sw_ready),
                .result_o (sw_res[g])
            );
        end
    endgenerate

    // Issues one op and waits (bounded) for valid_o; leaves the unit in DONE.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res);
        @(negedge clk);
        valid_i = 1'b1; op_i = o; op_a_i = a; op_b_i = b; ready_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        lat = 1;
        while (valid_o !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = result_o;
    endtask

    task automatic handshake();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; op_i = 2'b00; op_a_i = '0; op_b_i = '0; kill_i = 1'b0; ready_i = 1'b0;
        sw_valid = 1'b0; sw_ready = 1'b0; sw_op = 2'b00; sw_a = '0; sw_b = '0;
        #12;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 0", result_o); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic [31:0] res;
        issue(2'b00, 32'h3, 32'h3, lat, res);
        checks++; if (res !== 32'h5) begin failures++; $display("FAIL basic_result: got %h expected 00000005", res); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL basic_ready_in_done: got %b expected 0", ready_o); end
        handshake();
        issue(2'b11, 32'h3, 32'h3, lat, res);
        checks++; if (res !== 32'h5) begin failures++; $display("FAIL op11_result: got %h expected 00000005", res); end
        handshake();
    endtask

    task automatic test_ops();
        int lat; logic [31:0] res;
        logic [31:0] exp_msb [3];
        logic [31:0] exp_one [3];
        exp_msb[0] = 32'h0; exp_msb[1] = 32'h40000000; exp_msb[2] = 32'h80000000;
        exp_one[0] = 32'h55555555; exp_one[1] = 32'h55555555; exp_one[2] = 32'hAAAAAAAA;
        for (int i = 0; i < 3; i++) begin
            issue(2'(i), 32'h80000000, 32'h80000000, lat, res);
            checks++; if (res !== exp_msb[i]) begin failures++; $display("FAIL msb_op%0d: got %h expected %h", i, res, exp_msb[i]); end
            handshake();
            issue(2'(i), 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
            checks++; if (res !== exp_one[i]) begin failures++; $display("FAIL ones_op%0d: got %h expected %h", i, res, exp_one[i]); end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] res;
        issue(2'b00, 32'h3, 32'h3, lat, res);
        checks++; if (res !== 32'h5) begin failures++; $display("FAIL bp_result: got %h expected 00000005", res); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid_c%0d: got %b expected 1", i, valid_o); end
            checks++; if (result_o !== 32'h5) begin failures++; $display("FAIL bp_stable_c%0d: got %h expected 00000005", i, result_o); end
            checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_c%0d: got %b expected 0", i, ready_o); end
        end
        handshake();
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_after: got %b expected 1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_valid_after: got %b expected 0", valid_o); end
    endtask

    task automatic test_kill();
        int lat; logic [31:0] res;
        logic seen;
        @(negedge clk);
        valid_i = 1'b1; op_i = 2'b00; op_a_i = 32'h1234; op_b_i = 32'h80000077;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL kill_idle: got ready %b expected 1", ready_o); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (valid_o === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill_no_valid: got %b expected 0", seen); end
        checks++; if (result_o !== 32'h5) begin failures++; $display("FAIL kill_result_kept: got %h expected 00000005", result_o); end
        issue(2'b00, 32'h5, 32'h3, lat, res);
        checks++; if (res !== 32'hF) begin failures++; $display("FAIL after_kill_result: got %h expected 0000000f", res); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL after_kill_latency: got %0d expected 9", lat); end
        handshake();
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        valid_i = 1'b1; op_i = 2'b00; op_a_i = 32'h3; op_b_i = 32'h80000003;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0", valid_o); end
        checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL rst_mid_result: got %h expected 0", result_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b expected 1", ready_o); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_early_term();
        int lat; logic [31:0] res;
`ifdef CV32E40S_CLMUL_EARLY_TERM_EN
        issue(2'b00, 32'h7, 32'h1, lat, res);
        checks++; if (lat !== 2) begin failures++; $display("FAIL et_b1_latency: got %0d expected 2", lat); end
        checks++; if (res !== 32'h7) begin failures++; $display("FAIL et_b1_result: got %h expected 00000007", res); end
        handshake();
        issue(2'b00, 32'h7, 32'h0, lat, res);
        checks++; if (lat !== 1) begin failures++; $display("FAIL et_b0_latency: got %0d expected 1", lat); end
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL et_b0_result: got %h expected 0", res); end
        handshake();
        issue(2'b00, 32'h1, 32'h80000000, lat, res);
        checks++; if (lat !== 9) begin failures++; $display("FAIL et_bmsb_latency: got %0d expected 9", lat); end
        checks++; if (res !== 32'h80000000) begin failures++; $display("FAIL et_bmsb_result: got %h expected 80000000", res); end
        handshake();
`else
        issue(2'b00, 32'h7, 32'h1, lat, res);
        checks++; if (lat !== 9) begin failures++; $display("FAIL fixed_b1_latency: got %0d expected 9", lat); end
        checks++; if (res !== 32'h7) begin failures++; $display("FAIL fixed_b1_result: got %h expected 00000007", res); end
        handshake();
        issue(2'b00, 32'h7, 32'h0, lat, res);
        checks++; if (lat !== 9) begin failures++; $display("FAIL fixed_b0_latency: got %0d expected 9", lat); end
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL fixed_b0_result: got %h expected 0", res); end
        handshake();
`endif
    endtask

    task automatic test_step_sweep(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] exp);
        int lat [6];
        for (int i = 0; i < 6; i++) lat[i] = 0;
        @(negedge clk);
        sw_valid = 1'b1; sw_op = o; sw_a = a; sw_b = b; sw_ready = 1'b0;
        @(negedge clk);
        sw_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            for (int i = 0; i < 6; i++) begin
                if (sw_valid_o[i] === 1'b1 && lat[i] == 0) lat[i] = k;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (sw_res[i] !== exp) begin failures++; $display("FAIL sweep_step%0d_op%0d_result: got %h expected %h", 1 << i, o, sw_res[i], exp); end
            checks++; if (lat[i] !== (32 >> i) + 1) begin failures++; $display("FAIL sweep_step%0d_op%0d_latency: got %0d expected %0d", 1 << i, o, lat[i], (32 >> i) + 1); end
        end
        sw_ready = 1'b1;
        @(negedge clk);
        sw_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ops();
        test_backpressure();
        test_kill();
        test_early_term();
        test_step_sweep(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555);
        test_step_sweep(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555);
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
